spi_mstr_param: RTL and testbench

- Parametrised successor to the team's fixed 16-bit SPI master.
- Generalises the frame width, the SCLK divider and the number of slave selects.
- Adds a selectable SCLK idle polarity (SPI mode 0 or 3), a busy flag and a held read-data register.
- Sits between the control logic and the off-chip inertial sensor and A/D devices, sharing one SCLK/MOSI/MISO bus.

---
 rtl/spi_mstr_param.sv | 125 ++++++++++++
 tb/tb_spi_mstr_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr_param.sv
`timescale 1ns/1ps
// Parametrised SPI master: DATA_W-bit frames, MSB first, SCLK period 2^DIV_W clk, mode 0 or 3 by CPOL.
// Latency: SS_n low for H/2 + 2*H*DATA_W cycles; done/busy/rd_data update on the edge SS_n rises.
// Backpressure: wrt is only honoured while idle; requests during a frame are dropped, never queued.
module spi_mstr_param #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 5,
    parameter int NUM_SS = 2,
    parameter bit CPOL   = 1'b1,
    localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Divider is preloaded to 3H/2 so the first LOW phase begins exactly at wrap-around:
    // MSB=0 is the LOW half of each bit, MSB=1 the HIGH half.
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(3 * (2 ** (DIV_W - 2)));
    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'((2 ** (DIV_W - 1)) - 1);
    localparam logic [DIV_W-1:0] DIV_TOP  = '1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FRONT,
        LOW,
        HIGH
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shft;
    logic                miso_cap;
    logic [NUM_SS-1:0]   ss_mask_n;
    logic [DATA_W-1:0]   shft_nxt;

    always_comb begin
        ss_mask_n = '1;
        if (32'(ss_sel) < NUM_SS) begin
            ss_mask_n[ss_sel] = 1'b0;
        end else begin
            ss_mask_n[0] = 1'b0;
        end
    end

    assign shft_nxt = {shft[DATA_W-2:0], miso_cap};
    assign MOSI     = shft[DATA_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shft     <= '0;
            miso_cap <= 1'b0;
            SCLK     <= CPOL;
            SS_n     <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (state != IDLE) begin
                div_cnt <= div_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (wrt) begin
                        shft    <= cmd;
                        SS_n    <= ss_mask_n;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        bit_cnt <= '0;
                        div_cnt <= DIV_LOAD;
                        state   <= FRONT;
                    end
                end
                FRONT: begin
                    if (div_cnt == DIV_TOP) begin
                        SCLK  <= 1'b0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (div_cnt == DIV_MID) begin
                        SCLK     <= 1'b1;
                        miso_cap <= MISO;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_cnt == DIV_TOP) begin
                        shft    <= shft_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            SCLK    <= CPOL;
                            SS_n    <= '1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rd_data <= shft_nxt;
                            state   <= IDLE;
                        end else begin
                            SCLK  <= 1'b0;
                            state <= LOW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mstr_param.sv
`timescale 1ns/1ps
// Bench for spi_mstr_param: a mode-3 16-bit instance with a behavioural slave, and a mode-0 8-bit
// instance with MISO looped back to MOSI.
module tb_spi_mstr_param;

    localparam int A_DW     = 16;
    localparam int A_H      = 2 ** (5 - 1);
    localparam int A_SS_LOW = A_H / 2 + 2 * A_H * A_DW;
    localparam int B_DW     = 8;
    localparam int B_H      = 2 ** (3 - 1);
    localparam int B_SS_LOW = B_H / 2 + 2 * B_H * B_DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // instance A: defaults, mode 3
    logic        a_wrt    = 1'b0;
    logic [15:0] a_cmd    = '0;
    logic [0:0]  a_ss_sel = '0;
    logic        a_miso   = 1'b0;
    logic        a_sclk, a_mosi, a_busy, a_done;
    logic [1:0]  a_ss_n;
    logic [15:0] a_rd_data;

    spi_mstr_param dut_a (
        .clk(clk), .rst(rst), .wrt(a_wrt), .cmd(a_cmd), .ss_sel(a_ss_sel), .MISO(a_miso),
        .SCLK(a_sclk), .MOSI(a_mosi), .SS_n(a_ss_n), .busy(a_busy), .done(a_done), .rd_data(a_rd_data)
    );

    // instance B: 8-bit, DIV_W=3, mode 0, loopback
    logic        b_wrt    = 1'b0;
    logic [7:0]  b_cmd    = '0;
    logic [0:0]  b_ss_sel = '0;
    logic        b_miso;
    logic        b_sclk, b_mosi, b_busy, b_done;
    logic [1:0]  b_ss_n;
    logic [7:0]  b_rd_data;

    assign b_miso = b_mosi;

    spi_mstr_param #(.DATA_W(8), .DIV_W(3), .NUM_SS(2), .CPOL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .wrt(b_wrt), .cmd(b_cmd), .ss_sel(b_ss_sel), .MISO(b_miso),
        .SCLK(b_sclk), .MOSI(b_mosi), .SS_n(b_ss_n), .busy(b_busy), .done(b_done), .rd_data(b_rd_data)
    );

    // Mode-3 slave: shifts its reply out on SCLK falls, samples MOSI on SCLK rises.
    wire         a_ss_all = &a_ss_n;
    logic [15:0] s_out = '0;
    logic [15:0] s_in  = '0;
    int          s_nbits = 0;
    int          a_falls = 0;
    logic [15:0] resp_q[$];
    logic [15:0] rx_q[$];

    always @(negedge a_ss_all) begin
        s_in    = '0;
        s_nbits = 0;
        if (resp_q.size() > 0) s_out = resp_q.pop_front();
        else                   s_out = 16'h0000;
    end

    always @(posedge a_ss_all) begin
        if (s_nbits == A_DW) rx_q.push_back(s_in);
    end

    always @(negedge a_sclk) begin
        if (!a_ss_all) begin
            a_miso  = s_out[15];
            s_out   = {s_out[14:0], 1'b0};
            a_falls = a_falls + 1;
        end
    end

    always @(posedge a_sclk) begin
        if (!a_ss_all) begin
            s_in    = {s_in[14:0], a_mosi};
            s_nbits = s_nbits + 1;
        end
    end

    // Cycle-level monitors, sampled on the falling clk edge.
    int          a_ss0_cyc = 0, a_ss1_cyc = 0, a_rd_chg = 0, a_done_rises = 0, a_busy_falls = 0;
    int          b_ss_cyc = 0, b_hi_in = 0, b_hi_out = 0;
    logic [15:0] a_rd_prev = '0;

    always @(negedge clk) begin
        if (a_ss_n[0] === 1'b0) a_ss0_cyc = a_ss0_cyc + 1;
        if (a_ss_n[1] === 1'b0) a_ss1_cyc = a_ss1_cyc + 1;
        if (a_busy === 1'b1 && a_rd_data !== a_rd_prev) a_rd_chg = a_rd_chg + 1;
        a_rd_prev = a_rd_data;
        if (b_ss_n[0] === 1'b0) b_ss_cyc = b_ss_cyc + 1;
        if (b_sclk === 1'b1) begin
            if (b_ss_n === 2'b11) b_hi_out = b_hi_out + 1;
            else                  b_hi_in  = b_hi_in + 1;
        end
    end

    always @(posedge a_done) a_done_rises = a_done_rises + 1;
    always @(negedge a_busy) a_busy_falls = a_busy_falls + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_start(input logic [15:0] c, input logic [0:0] sel);
        @(negedge clk);
        a_cmd    = c;
        a_ss_sel = sel;
        a_wrt    = 1'b1;
        @(negedge clk);
        a_wrt    = 1'b0;
    endtask

    task automatic a_wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic a_pop_rx(input string tag, input logic [15:0] c);
        logic [15:0] rx;
        rx = 16'hxxxx;
        if (rx_q.size() > 0) rx = rx_q.pop_front();
        check({tag, "_slave_rx"}, 32'(rx), 32'(c));
    endtask

    task automatic a_frame(input string tag, input logic [15:0] c, input logic [15:0] r, input logic [0:0] sel);
        int ss0, ss1, fl;
        ss0 = a_ss0_cyc;
        ss1 = a_ss1_cyc;
        fl  = a_falls;
        resp_q.push_back(r);
        a_start(c, sel);
        a_wait_done(tag);
        check({tag, "_rd_data"}, 32'(a_rd_data), 32'(r));
        a_pop_rx(tag, c);
        check({tag, "_ss0_low"}, 32'(a_ss0_cyc - ss0), (sel == 1'b0) ? 32'(A_SS_LOW) : 32'd0);
        check({tag, "_ss1_low"}, 32'(a_ss1_cyc - ss1), (sel == 1'b1) ? 32'(A_SS_LOW) : 32'd0);
        check({tag, "_sclk_falls"}, 32'(a_falls - fl), 32'(A_DW));
        check({tag, "_sclk_idle"}, 32'(a_sclk), 32'd1);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
    endtask

    task automatic b_frame(input string tag, input logic [7:0] c);
        int ss0, hi_in0, hi_out0;
        bit seen;
        ss0     = b_ss_cyc;
        hi_in0  = b_hi_in;
        hi_out0 = b_hi_out;
        seen    = 1'b0;
        @(negedge clk);
        b_cmd = c;
        b_wrt = 1'b1;
        @(negedge clk);
        b_wrt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 32'(seen), 32'd1);
        check({tag, "_rd_data"}, 32'(b_rd_data), 32'(c));
        check({tag, "_ss_low"}, 32'(b_ss_cyc - ss0), 32'(B_SS_LOW));
        check({tag, "_sclk_hi_cycles"}, 32'(b_hi_in - hi_in0), 32'(B_DW * B_H));
        check({tag, "_sclk_hi_idle"}, 32'(b_hi_out - hi_out0), 32'd0);
        check({tag, "_sclk_end"}, 32'(b_sclk), 32'd0);
        check({tag, "_ss_end"}, 32'(b_ss_n), 32'h3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no summary, expected summary");
        $fatal(1, "time limit");
    end

    initial begin
        int d0, bf0, rc0, ss0;
        logic [15:0] c, r;
        logic [0:0]  sel;

        repeat (3) @(negedge clk);
        check("rst_a_ss_n", 32'(a_ss_n), 32'h3);
        check("rst_a_sclk", 32'(a_sclk), 32'd1);
        check("rst_a_mosi", 32'(a_mosi), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_done", 32'(a_done), 32'd0);
        check("rst_a_rd_data", 32'(a_rd_data), 32'd0);
        check("rst_b_sclk", 32'(b_sclk), 32'd0);
        check("rst_b_ss_n", 32'(b_ss_n), 32'h3);
        rst = 1'b0;

        // Abort after five bits with an asynchronous reset between clock edges.
        resp_q.push_back(16'hBEEF);
        a_start(16'hA5C3, 1'b0);
        for (int i = 0; i < 600 && s_nbits < 5; i++) @(negedge clk);
        check("abort_reach_5_bits", 32'(s_nbits >= 5), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_ss_n", 32'(a_ss_n), 32'h3);
        check("abort_sclk", 32'(a_sclk), 32'd1);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        check("abort_rd_data", 32'(a_rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_no_slave_word", 32'(rx_q.size()), 32'd0);
        resp_q.delete();

        a_frame("post_abort", 16'h5A3C, 16'hC001, 1'b0);
        a_frame("main", 16'hA5C3, 16'h1234, 1'b0);
        a_frame("ss_sel1", 16'hFFFF, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            c   = 16'($urandom);
            r   = 16'($urandom);
            sel = 1'($urandom_range(0, 1));
            a_frame("random", c, r, sel);
        end

        // Second wrt mid-frame with a different cmd must be dropped.
        d0  = a_done_rises;
        bf0 = a_busy_falls;
        ss0 = a_ss0_cyc;
        resp_q.push_back(16'h6B2D);
        a_start(16'h1E87, 1'b0);
        repeat (200) @(negedge clk);
        a_cmd = 16'hFFFF;
        a_wrt = 1'b1;
        @(negedge clk);
        a_wrt = 1'b0;
        check("midwrt_busy", 32'(a_busy), 32'd1);
        a_wait_done("midwrt");
        check("midwrt_rd_data", 32'(a_rd_data), 32'h6B2D);
        a_pop_rx("midwrt", 16'h1E87);
        repeat (150) @(negedge clk);
        check("midwrt_done_count", 32'(a_done_rises - d0), 32'd1);
        check("midwrt_busy_falls", 32'(a_busy_falls - bf0), 32'd1);
        check("midwrt_ss_low", 32'(a_ss0_cyc - ss0), 32'(A_SS_LOW));
        check("midwrt_done_held", 32'(a_done), 32'd1);

        // wrt held high across two frames.
        d0  = a_done_rises;
        rc0 = a_rd_chg;
        resp_q.push_back(16'h00FF);
        resp_q.push_back(16'hFF00);
        @(negedge clk);
        a_cmd    = 16'h9C41;
        a_ss_sel = 1'b0;
        a_wrt    = 1'b1;
        a_wait_done("b2b_first");
        check("b2b_first_rd_data", 32'(a_rd_data), 32'h00FF);
        check("b2b_gap_ss_n", 32'(a_ss_n), 32'h3);
        @(negedge clk);
        check("b2b_done_cleared", 32'(a_done), 32'd0);
        check("b2b_restart_busy", 32'(a_busy), 32'd1);
        repeat (260) @(negedge clk);
        check("b2b_rd_data_mid", 32'(a_rd_data), 32'h00FF);
        a_wait_done("b2b_second");
        a_wrt = 1'b0;
        check("b2b_second_rd_data", 32'(a_rd_data), 32'hFF00);
        check("b2b_done_count", 32'(a_done_rises - d0), 32'd2);
        check("b2b_rd_stable_busy", 32'(a_rd_chg - rc0), 32'd0);
        a_pop_rx("b2b_first", 16'h9C41);
        a_pop_rx("b2b_second", 16'h9C41);

        // Mode-0, 8-bit instance with loopback.
        b_frame("b_main", 8'h3C);
        for (int k = 0; k < 3; k++) begin
            b_frame("b_random", 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
